// File: rtl/qpsk_frame_sync.sv
// rtl/qpsk_frame_sync.sv - QPSK unique-word frame synchronizer with flywheel lock
// Define FSYNC_STATS_EN to build the frame_cnt / lost_cnt statistics counters.
module qpsk_frame_sync #(
   parameter logic [31:0] UW          = 32'hF9A4_2BB1,
   parameter int          PAYLOAD_LEN = 64,
   parameter int          MAX_ERR     = 2,
   parameter int          LOSS_CNT    = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [1:0]  dibit,
   input  logic        bitsync,
   output logic        lock,
   output logic        pay_valid,
   output logic [1:0]  pay_data,
   output logic        sof,
   output logic        eof,
   output logic        uw_hit,
   output logic [15:0] frame_cnt,
   output logic [7:0]  lost_cnt
);
   typedef enum logic [1:0] {IDLE, SEARCH, PAYLOAD, CHECK} state_t;

   localparam logic [9:0] LAST_SYM = 10'(PAYLOAD_LEN - 1);
   localparam logic [5:0] ERR_LIM  = 6'(MAX_ERR);
   localparam logic [2:0] MISS_LIM = 3'(LOSS_CNT);

   state_t      state, state_nx;
   logic [31:0] window, window_nx, shifted;
   logic [9:0]  sym_cnt, sym_cnt_nx;
   logic [2:0]  miss, miss_nx;
   logic        lock_nx, pay_valid_nx, sof_nx, eof_nx, uw_hit_nx;
   logic [1:0]  pay_data_nx;
   logic [5:0]  err_cnt;
   logic        match;

   // Match is judged on the window as it will look after this symbol shifts in.
   assign shifted = {window[29:0], dibit};

   always_comb begin
      err_cnt = '0;
      for (int i = 0; i < 32; i++) begin
         err_cnt = err_cnt + {5'd0, shifted[i] ^ UW[i]};
      end
   end

   assign match = (err_cnt <= ERR_LIM);

   always_comb begin
      state_nx     = state;
      window_nx    = window;
      sym_cnt_nx   = sym_cnt;
      miss_nx      = miss;
      pay_valid_nx = 1'b0;
      pay_data_nx  = pay_data;
      sof_nx       = 1'b0;
      eof_nx       = 1'b0;
      uw_hit_nx    = 1'b0;

      if (!en) begin
         state_nx   = IDLE;
         window_nx  = '0;
         sym_cnt_nx = '0;
         miss_nx    = '0;
      end else begin
         case (state)
            IDLE: begin
               state_nx   = SEARCH;
               window_nx  = '0;
               sym_cnt_nx = '0;
               miss_nx    = '0;
            end
            SEARCH: begin
               if (bitsync) begin
                  window_nx = shifted;
                  if (match) begin
                     uw_hit_nx  = 1'b1;
                     state_nx   = PAYLOAD;
                     sym_cnt_nx = '0;
                     miss_nx    = '0;
                  end
               end
            end
            PAYLOAD: begin
               if (bitsync) begin
                  window_nx    = shifted;
                  pay_valid_nx = 1'b1;
                  pay_data_nx  = dibit;
                  sof_nx       = (sym_cnt == '0);
                  eof_nx       = (sym_cnt == LAST_SYM);
                  if (sym_cnt == LAST_SYM) begin
                     state_nx   = CHECK;
                     sym_cnt_nx = '0;
                  end else begin
                     sym_cnt_nx = sym_cnt + 10'd1;
                  end
               end
            end
            CHECK: begin
               if (bitsync) begin
                  window_nx = shifted;
                  if (sym_cnt == 10'd15) begin
                     sym_cnt_nx = '0;
                     if (match) begin
                        uw_hit_nx = 1'b1;
                        miss_nx   = '0;
                        state_nx  = PAYLOAD;
                     end else if (miss + 3'd1 >= MISS_LIM) begin
                        miss_nx  = '0;
                        state_nx = SEARCH;
                     end else begin
                        // Flywheel: assume the UW was corrupted and keep the frame cadence.
                        miss_nx  = miss + 3'd1;
                        state_nx = PAYLOAD;
                     end
                  end else begin
                     sym_cnt_nx = sym_cnt + 10'd1;
                  end
               end
            end
            default: state_nx = IDLE;
         endcase
      end

      lock_nx = (state_nx == PAYLOAD) || (state_nx == CHECK);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         window    <= '0;
         sym_cnt   <= '0;
         miss      <= '0;
         lock      <= 1'b0;
         pay_valid <= 1'b0;
         pay_data  <= '0;
         sof       <= 1'b0;
         eof       <= 1'b0;
         uw_hit    <= 1'b0;
      end else begin
         state     <= state_nx;
         window    <= window_nx;
         sym_cnt   <= sym_cnt_nx;
         miss      <= miss_nx;
         lock      <= lock_nx;
         pay_valid <= pay_valid_nx;
         pay_data  <= pay_data_nx;
         sof       <= sof_nx;
         eof       <= eof_nx;
         uw_hit    <= uw_hit_nx;
      end
   end

`ifdef FSYNC_STATS_EN
   logic [15:0] frame_q;
   logic [7:0]  lost_q;
   logic        lost;

   assign lost = ((state == PAYLOAD) || (state == CHECK)) && (state_nx == SEARCH);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_q <= '0;
         lost_q  <= '0;
      end else begin
         if (uw_hit_nx && (frame_q != 16'hFFFF)) begin
            frame_q <= frame_q + 16'd1;
         end
         if (lost && (lost_q != 8'hFF)) begin
            lost_q <= lost_q + 8'd1;
         end
      end
   end

   assign frame_cnt = frame_q;
   assign lost_cnt  = lost_q;
`else
   assign frame_cnt = '0;
   assign lost_cnt  = '0;
`endif

endmodule

// File: tb/tb_qpsk_frame_sync.sv
// tb/tb_qpsk_frame_sync.sv - scoreboard bench for qpsk_frame_sync
// Reference model works on a dibit history queue and plain frame counters.
module tb_qpsk_frame_sync;
   localparam logic [31:0] UW   = 32'hF9A4_2BB1;
   localparam int          PL   = 64;
   localparam int          MAXE = 2;
   localparam int          LOSS = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        bitsync = 1'b0;
   logic [1:0]  dibit = 2'b00;
   logic        lock, pay_valid, sof, eof, uw_hit;
   logic [1:0]  pay_data;
   logic [15:0] frame_cnt;
   logic [7:0]  lost_cnt;

   qpsk_frame_sync dut (
      .clk(clk), .rst(rst), .en(en), .dibit(dibit), .bitsync(bitsync),
      .lock(lock), .pay_valid(pay_valid), .pay_data(pay_data), .sof(sof),
      .eof(eof), .uw_hit(uw_hit), .frame_cnt(frame_cnt), .lost_cnt(lost_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       uw;
      logic [1:0] data;
      logic       sof;
      logic       eof;
      int         at;
   } ev_t;

   ev_t        expq[$];
   ev_t        mon_ev;
   int         total = 0;
   int         bad = 0;
   int         edge_n = 0;

   // mode: 0 idle, 1 search, 2 payload, 3 check
   int         mode = 0;
   logic [1:0] hist[$];
   int         cnt = 0;
   int         miss = 0;
   int         frames_exp = 0;
   int         lost_exp = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   function automatic int uw_errors();
      int         e = 0;
      int         pad = 16 - hist.size();
      logic [1:0] u, h;
      for (int k = 0; k < 16; k++) begin
         u = 2'((UW >> (30 - 2 * k)) & 32'h3);
         h = (k < pad) ? 2'b00 : hist[k - pad];
         e += int'(u[1] != h[1]) + int'(u[0] != h[0]);
      end
      return e;
   endfunction

   function automatic void push_ev(logic u, logic [1:0] d, logic s, logic e);
      ev_t x;
      x.uw = u; x.data = d; x.sof = s; x.eof = e; x.at = edge_n;
      expq.push_back(x);
   endfunction

   function automatic void model_step(logic e, logic bs, logic [1:0] d);
      if (rst) begin
         mode = 0; hist.delete(); expq.delete();
         cnt = 0; miss = 0; frames_exp = 0; lost_exp = 0;
         return;
      end
      if (!e) begin
         mode = 0;
         return;
      end
      if (mode == 0) begin
         mode = 1; hist.delete(); cnt = 0; miss = 0;
         return;
      end
      if (!bs) return;
      hist.push_back(d);
      if (hist.size() > 16) void'(hist.pop_front());
      case (mode)
         1: if (uw_errors() <= MAXE) begin
               push_ev(1'b1, 2'b00, 1'b0, 1'b0);
               frames_exp++; mode = 2; cnt = 0; miss = 0;
            end
         2: begin
               push_ev(1'b0, d, cnt == 0, cnt == PL - 1);
               cnt++;
               if (cnt == PL) begin mode = 3; cnt = 0; end
            end
         3: begin
               cnt++;
               if (cnt == 16) begin
                  cnt = 0;
                  if (uw_errors() <= MAXE) begin
                     push_ev(1'b1, 2'b00, 1'b0, 1'b0);
                     frames_exp++; miss = 0; mode = 2;
                  end else begin
                     miss++;
                     if (miss >= LOSS) begin mode = 1; lost_exp++; miss = 0; end
                     else mode = 2;
                  end
               end
            end
         default: ;
      endcase
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         check("lock", 32'(lock), (mode == 2 || mode == 3) ? 32'd1 : 32'd0);
`ifdef FSYNC_STATS_EN
         check("frame_cnt", 32'(frame_cnt), frames_exp);
         check("lost_cnt", 32'(lost_cnt), lost_exp);
`else
         check("frame_cnt_zero", 32'(frame_cnt), 32'd0);
         check("lost_cnt_zero", 32'(lost_cnt), 32'd0);
`endif
         if (pay_valid || uw_hit) begin
            if (expq.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_strobe: pay_valid=%b uw_hit=%b, expected none (edge %0d)",
                        pay_valid, uw_hit, edge_n);
            end else begin
               mon_ev = expq.pop_front();
               check("strobe_time", edge_n, mon_ev.at);
               check("uw_hit", 32'(uw_hit), 32'(mon_ev.uw));
               check("pay_valid", 32'(pay_valid), 32'(!mon_ev.uw));
               if (!mon_ev.uw) begin
                  check("pay_data", 32'(pay_data), 32'(mon_ev.data));
                  check("sof", 32'(sof), 32'(mon_ev.sof));
                  check("eof", 32'(eof), 32'(mon_ev.eof));
               end
            end
         end else if (expq.size() != 0 && expq[0].at <= edge_n) begin
            total++; bad++;
            $display("FAIL missing_strobe: got none, expected uw=%b at edge %0d", expq[0].uw, expq[0].at);
            void'(expq.pop_front());
         end
      end
   end

   task automatic tick(input logic e, input logic bs, input logic [1:0] d);
      en = e; bitsync = bs; dibit = d;
      @(posedge clk);
      edge_n++;
      model_step(e, bs, d);
      #1;
   endtask

   task automatic sym(input logic [1:0] d, input int maxgap);
      int g = $urandom_range(maxgap, 0);
      repeat (g) tick(1'b1, 1'b0, 2'($urandom));
      tick(1'b1, 1'b1, d);
   endtask

   task automatic send_word(input logic [31:0] w, input int maxgap);
      for (int k = 0; k < 16; k++) sym(w[31 - 2 * k -: 2], maxgap);
   endtask

   task automatic payload(input int n, input int maxgap);
      for (int k = 0; k < n; k++) sym(2'($urandom), maxgap);
   endtask

   function automatic logic [31:0] corrupt(input int n);
      logic [31:0] m = '0;
      while ($countones(m) < n) m[$urandom_range(31, 0)] = 1'b1;
      return UW ^ m;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", {1'b0, lock, pay_valid, pay_data, sof, eof, uw_hit, frame_cnt, lost_cnt}, 32'd0);
      rst = 1'b0;
      repeat (3) tick(1'b1, 1'b0, 2'b00);

      // exact UW then cyclic 0..3 payload
      send_word(UW, 0);
      check("uw_hit_exact", 32'(uw_hit), 32'd1);
      for (int k = 0; k < PL; k++) sym(2'(k % 4), 0);
      check("lock_after_frame", 32'(lock), 32'd1);

      // two bit errors accepted in CHECK
      send_word(corrupt(2), 1);
      check("uw_hit_2err", 32'(uw_hit), 32'd1);
      payload(PL, 1);

      // one miss then a good UW: flywheel keeps lock
      send_word(corrupt(5), 1);
      check("lock_after_miss1", 32'(lock), 32'd1);
      payload(PL, 1);
      send_word(UW, 1);
      check("uw_hit_recover", 32'(uw_hit), 32'd1);
      payload(PL, 2);

      // three consecutive misses drop lock
      for (int r = 0; r < 3; r++) begin
         send_word(corrupt(4), 1);
         check("lock_miss_seq", 32'(lock), (r < 2) ? 32'd1 : 32'd0);
         if (r < 2) payload(PL, 1);
      end

      // three bit errors in SEARCH from a clean window: no lock
      tick(1'b0, 1'b0, 2'b00);
      repeat (2) tick(1'b1, 1'b0, 2'b00);
      send_word(corrupt(3), 0);
      check("no_lock_3err", {30'd0, lock, uw_hit}, 32'd0);

      // en drops together with a payload bitsync
      tick(1'b0, 1'b0, 2'b00);
      repeat (2) tick(1'b1, 1'b0, 2'b00);
      send_word(UW, 0);
      payload(10, 1);
      tick(1'b0, 1'b1, 2'b11);
      check("en_drop", {30'd0, lock, pay_valid}, 32'd0);
      repeat (2) tick(1'b1, 1'b0, 2'b00);

      // asynchronous reset mid-payload
      send_word(UW, 0);
      payload(7, 0);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("rst_async", {1'b0, lock, pay_valid, pay_data, sof, eof, uw_hit, frame_cnt, lost_cnt}, 32'd0);
      tick(1'b1, 1'b0, 2'b00);
      rst = 1'b0;
      tick(1'b1, 1'b0, 2'b00);
      send_word(UW, 0);
      check("uw_hit_after_rst", 32'(uw_hit), 32'd1);

      // randomized traffic
      repeat (40) begin
         int r = $urandom_range(9, 0);
         if (r < 5) begin
            send_word(corrupt($urandom_range(4, 0)), 2);
         end else if (r < 9) begin
            payload($urandom_range(80, 1), 2);
         end else begin
            tick(1'b0, 1'($urandom), 2'($urandom));
            repeat (2) tick(1'b1, 1'b0, 2'b00);
         end
      end

      repeat (3) tick(1'b1, 1'b0, 2'b00);
      check("scoreboard_drained", expq.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
